// File: rtl/column_frame_strobe_gen_pkg.sv
// -----------------------------------------------------------------------------
// column_frame_strobe_gen_pkg
//   Shared definitions for the per-column frame-strobe generator:
//   sequencer state encoding, default phase timings and width helpers.
// -----------------------------------------------------------------------------
package column_frame_strobe_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    localparam int DEF_SETUP_CYCLES  = 1;
    localparam int DEF_STROBE_CYCLES = 1;
    localparam int DEF_HOLD_CYCLES   = 1;

    // Bits needed to index n items (never less than 1).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/column_frame_strobe_gen_phase_counter.sv
// -----------------------------------------------------------------------------
// strobe_phase_counter
//   Loadable down-counter with zero flag. One instance times the SETUP,
//   STROBE and HOLD phases in turn; the sequencer reloads it on each phase
//   entry with (phase length - 1) and decrements until zero.
// Ports:
//   CLK, resetn   clock / async active-low reset
//   load          load load_val (has priority over dec)
//   load_val      value to load
//   dec           decrement by one (saturates at zero)
//   zero          count is zero
// -----------------------------------------------------------------------------
module strobe_phase_counter #(
    parameter int Width = 2
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - Width'(1);
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/column_frame_strobe_gen.sv
// -----------------------------------------------------------------------------
// column_frame_strobe_gen
//   Drives the FrameStrobe vector at the bottom of one fabric column.
//   Requests addressed to another column are consumed and dropped at one per
//   cycle. A matching request runs SETUP -> STROBE -> HOLD so FrameData is
//   stable around the latch; FrameStrobe is a registered one-hot.
//
// Optional feature: define FRAME_STROBE_RANGE_CHECK_EN to reject matching
//   requests whose frame index is >= MaxFramesPerCol (no sequence, sticky err).
//   Without it, such requests run a normal sequence with no strobe bit set and
//   err is tied low.
//
// Ports:
//   CLK, resetn    configuration clock / async active-low reset
//   req_valid      request valid         req_ready   accept (high only in IDLE)
//   req_col        target column         req_frame   target frame index
//   FrameStrobe    one-hot frame strobe  busy        sequence in progress
//   err            sticky out-of-range   err_clr     clears err (set wins)
// -----------------------------------------------------------------------------
module column_frame_strobe_gen
    import column_frame_strobe_gen_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int ColumnIndex     = 0,
    parameter int ColAddrWidth    = 5,
    parameter int SetupCycles     = DEF_SETUP_CYCLES,
    parameter int StrobeCycles    = DEF_STROBE_CYCLES,
    parameter int HoldCycles      = DEF_HOLD_CYCLES
) (
    input  logic                                  CLK,
    input  logic                                  resetn,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [ColAddrWidth-1:0]               req_col,
    input  logic [idx_width(MaxFramesPerCol)-1:0] req_frame,
    output logic [MaxFramesPerCol-1:0]            FrameStrobe,
    output logic                                  busy,
    output logic                                  err,
    input  logic                                  err_clr
);

    localparam int FW = idx_width(MaxFramesPerCol);
    localparam int CW = idx_width(max3(SetupCycles, StrobeCycles, HoldCycles));

    localparam logic [CW-1:0] SETUP_LOAD  = CW'(SetupCycles - 1);
    localparam logic [CW-1:0] STROBE_LOAD = CW'(StrobeCycles - 1);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'((HoldCycles > 0) ? HoldCycles - 1 : 0);

    state_e                     state_q, state_d;
    logic [FW-1:0]              frame_q, frame_d;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;

    logic          cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0] cnt_load_val;
    logic          col_match;
    logic          err_set;

    assign col_match = (req_col == ColAddrWidth'(ColumnIndex));

`ifdef FRAME_STROBE_RANGE_CHECK_EN
    localparam logic [FW:0] MAX_FRAMES = (FW+1)'(MaxFramesPerCol);
    logic frame_oor;
    assign frame_oor = ({1'b0, req_frame} >= MAX_FRAMES);
`endif

    strobe_phase_counter #(.Width(CW)) u_phase_cnt (
        .CLK      (CLK),
        .resetn   (resetn),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            frame_q  <= '0;
            strobe_q <= '0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            strobe_q <= strobe_d;
        end
    end

    // Next-state logic. In IDLE req_ready is high, so req_valid alone means
    // the request is accepted this edge; foreign requests simply fall through.
    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        err_set      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && col_match) begin
`ifdef FRAME_STROBE_RANGE_CHECK_EN
                    if (frame_oor) begin
                        err_set = 1'b1;
                    end else begin
                        state_d      = ST_SETUP;
                        frame_d      = req_frame;
                        cnt_load     = 1'b1;
                        cnt_load_val = SETUP_LOAD;
                    end
`else
                    state_d      = ST_SETUP;
                    frame_d      = req_frame;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETUP_LOAD;
`endif
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d      = ST_STROBE;
                    cnt_load     = 1'b1;
                    cnt_load_val = STROBE_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt_zero) begin
                    if (HoldCycles == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d      = ST_HOLD;
                        cnt_load     = 1'b1;
                        cnt_load_val = HOLD_LOAD;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) state_d = ST_IDLE;
                else          cnt_dec = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobe register input follows the *next* state so the bit is high for
    // exactly the cycles spent in STROBE. Indices >= MaxFramesPerCol match no
    // bit and so produce an empty strobe.
    always_comb begin
        strobe_d = '0;
        if (state_d == ST_STROBE) begin
            for (int i = 0; i < MaxFramesPerCol; i++)
                strobe_d[i] = (frame_d == FW'(i));
        end
    end

    // Outputs
    always_comb begin
        req_ready   = (state_q == ST_IDLE);
        busy        = (state_q != ST_IDLE);
        FrameStrobe = strobe_q;
    end

`ifdef FRAME_STROBE_RANGE_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (err_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_err;
    assign unused_err = err_clr ^ err_set;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_column_frame_strobe_gen.sv
module tb_column_frame_strobe_gen;

    logic        CLK = 1'b0;
    logic        resetn;
    logic        va, vb;
    logic [4:0]  req_col;
    logic [4:0]  req_frame;
    logic        err_clr;

    logic        ra, rb, busya, busyb, erra, errb;
    logic [19:0] fsa, fsb;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    // a: default timing; b: setup 2, strobe 3, no hold
    column_frame_strobe_gen #(.MaxFramesPerCol(20), .ColumnIndex(3), .ColAddrWidth(5))
    dut_a (
        .CLK(CLK), .resetn(resetn), .req_valid(va), .req_ready(ra),
        .req_col(req_col), .req_frame(req_frame), .FrameStrobe(fsa),
        .busy(busya), .err(erra), .err_clr(err_clr)
    );

    column_frame_strobe_gen #(.MaxFramesPerCol(20), .ColumnIndex(3), .ColAddrWidth(5),
                              .SetupCycles(2), .StrobeCycles(3), .HoldCycles(0))
    dut_b (
        .CLK(CLK), .resetn(resetn), .req_valid(vb), .req_ready(rb),
        .req_col(req_col), .req_frame(req_frame), .FrameStrobe(fsb),
        .busy(busyb), .err(errb), .err_clr(err_clr)
    );

    task automatic test_reset();
        resetn = 1'b0; va = 1'b0; vb = 1'b0;
        req_col = '0; req_frame = '0; err_clr = 1'b0;
        #12;
        tests++; if (fsa !== 20'h0) begin fails++; $display("FAIL reset_fs got %h exp 0", fsa); end
        tests++; if (ra !== 1'b1)   begin fails++; $display("FAIL reset_ready got %b exp 1", ra); end
        tests++; if (busya !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busya); end
        tests++; if (erra !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", erra); end
        tests++; if (rb !== 1'b1 || fsb !== 20'h0) begin fails++; $display("FAIL reset_b got rdy=%b fs=%h exp 1/0", rb, fsb); end
        @(negedge CLK); resetn = 1'b1;
        @(negedge CLK);
    endtask

    // Accept at edge N; samples k are taken at the negedge after edge N+k.
    task automatic test_single();
        logic [19:0] exp_fs [5];
        logic        exp_rdy [5];
        exp_fs  = '{20'h0, 20'h00020, 20'h0, 20'h0, 20'h0};
        exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        req_col = 5'd3; req_frame = 5'd5; va = 1'b1;
        @(negedge CLK); va = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (fsa !== exp_fs[k] || ra !== exp_rdy[k]) begin
                fails++;
                $display("FAIL single_k%0d got fs=%h rdy=%b exp fs=%h rdy=%b", k, fsa, ra, exp_fs[k], exp_rdy[k]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_mismatch();
        int acc = 0;
        logic bad = 1'b0;
        req_col = 5'd7; req_frame = 5'd2; va = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (va && ra) acc++;
            @(negedge CLK);
            if (fsa !== 20'h0 || busya !== 1'b0 || ra !== 1'b1) bad = 1'b1;
        end
        va = 1'b0;
        tests++; if (acc != 4) begin fails++; $display("FAIL mismatch_accepts got %0d exp 4", acc); end
        tests++; if (bad) begin fails++; $display("FAIL mismatch_idle got activity exp fs=0 busy=0 rdy=1"); end
        @(negedge CLK);
    endtask

    task automatic test_long_strobe();
        logic [19:0] exp_fs [7];
        logic        exp_rdy [7];
        exp_fs  = '{20'h0, 20'h0, 20'h80000, 20'h80000, 20'h80000, 20'h0, 20'h0};
        exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        req_col = 5'd3; req_frame = 5'd19; vb = 1'b1;
        @(negedge CLK); vb = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tests++;
            if (fsb !== exp_fs[k] || rb !== exp_rdy[k]) begin
                fails++;
                $display("FAIL long_k%0d got fs=%h rdy=%b exp fs=%h rdy=%b", k, fsb, rb, exp_fs[k], exp_rdy[k]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset_mid();
        req_col = 5'd3; req_frame = 5'd5; va = 1'b1;
        @(negedge CLK); va = 1'b0;
        @(negedge CLK);
        tests++; if (fsa !== 20'h00020) begin fails++; $display("FAIL rstmid_pre got %h exp 00020", fsa); end
        #1 resetn = 1'b0;
        #1;
        tests++; if (fsa !== 20'h0 || busya !== 1'b0) begin fails++; $display("FAIL rstmid_async got fs=%h busy=%b exp 0/0", fsa, busya); end
        @(negedge CLK); resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            tests++;
            if (fsa !== 20'h0 || ra !== 1'b1) begin
                fails++; $display("FAIL rstmid_after_k%0d got fs=%h rdy=%b exp 0/1", k, fsa, ra);
            end
        end
    endtask

    task automatic test_range();
        req_col = 5'd3; req_frame = 5'd25; va = 1'b1;
        @(negedge CLK); va = 1'b0;
`ifdef FRAME_STROBE_RANGE_CHECK_EN
        tests++; if (erra !== 1'b1 || ra !== 1'b1 || busya !== 1'b0) begin
            fails++; $display("FAIL range_reject got err=%b rdy=%b busy=%b exp 1/1/0", erra, ra, busya); end
        @(negedge CLK);
        tests++; if (fsa !== 20'h0 || erra !== 1'b1) begin
            fails++; $display("FAIL range_sticky got fs=%h err=%b exp 0/1", fsa, erra); end
        err_clr = 1'b1;
        @(negedge CLK); err_clr = 1'b0;
        tests++; if (erra !== 1'b0) begin fails++; $display("FAIL range_clr got %b exp 0", erra); end
        err_clr = 1'b1; va = 1'b1;
        @(negedge CLK); err_clr = 1'b0; va = 1'b0;
        tests++; if (erra !== 1'b1) begin fails++; $display("FAIL range_set_wins got %b exp 1", erra); end
        err_clr = 1'b1;
        @(negedge CLK); err_clr = 1'b0;
`else
        // Index 25 fits in 5 bits: sequence runs, but no bit is strobed.
        tests++; if (busya !== 1'b1 || erra !== 1'b0) begin
            fails++; $display("FAIL range_seq got busy=%b err=%b exp 1/0", busya, erra); end
        for (int k = 1; k < 4; k++) begin
            @(negedge CLK);
            tests++; if (fsa !== 20'h0 || ra !== (k == 3)) begin
                fails++; $display("FAIL range_k%0d got fs=%h rdy=%b exp 0/%0d", k, fsa, ra, (k == 3)); end
        end
        err_clr = 1'b1;
        @(negedge CLK); err_clr = 1'b0;
        tests++; if (erra !== 1'b0) begin fails++; $display("FAIL range_err_tied got %b exp 0", erra); end
`endif
        @(negedge CLK);
    endtask

    // Two requests, frame 0 then 1. Between strobes the column sees hold (1),
    // the idle/accept cycle (1) and setup (1): 3 strobe-free cycles.
    task automatic test_back_to_back();
        int n_acc = 0;
        int t0 = -1, t1 = -1, c0 = 0, c1 = 0;
        logic multi = 1'b0;
        logic acc_now;
        req_col = 5'd3; req_frame = 5'd0; va = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (n_acc == 1 && !va && ra) begin req_frame = 5'd1; va = 1'b1; end
            acc_now = va && ra;
            if (acc_now) n_acc++;
            @(negedge CLK);
            if (acc_now) va = 1'b0;
            if (fsa == 20'h1) begin if (t0 < 0) t0 = c; c0++; end
            else if (fsa == 20'h2) begin if (t1 < 0) t1 = c; c1++; end
            else if (fsa !== 20'h0) multi = 1'b1;
        end
        tests++; if (n_acc != 2) begin fails++; $display("FAIL b2b_accepts got %0d exp 2", n_acc); end
        tests++; if (c0 != 1 || c1 != 1) begin fails++; $display("FAIL b2b_widths got %0d,%0d exp 1,1", c0, c1); end
        tests++; if (multi) begin fails++; $display("FAIL b2b_onehot got overlapping bits exp single bit"); end
        tests++; if (t0 < 0 || t1 - t0 - 1 != 3) begin
            fails++; $display("FAIL b2b_gap got t0=%0d t1=%0d exp gap 3", t0, t1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mismatch();
        test_long_strobe();
        test_reset_mid();
        test_range();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule
